// File: rtl/rfu_mp_if.sv
// Bundle of dispatch, CDB and read-back signals between the dispatch stage
// and the multi-port register status file.
//   master : dispatch/CDB side, drives allocation, source addresses, CDB, flush
//   slave  : register file side, returns source data/busy/tag and busy_vec
interface rfu_mp_if #(
    parameter int TAG_W    = 4,
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_DISP = 2,
    parameter int NUM_CDB  = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_DISP-1:0]       disp_rd_wr;
    logic [NUM_DISP*AW-1:0]    disp_rd_addr;
    logic [NUM_DISP*TAG_W-1:0] disp_rd_tag;
    logic [NUM_DISP*AW-1:0]    disp_rs1_addr;
    logic [NUM_DISP*AW-1:0]    disp_rs2_addr;
    logic [NUM_DISP*XLEN-1:0]  disp_rs1_rdata;
    logic [NUM_DISP*XLEN-1:0]  disp_rs2_rdata;
    logic [NUM_DISP-1:0]       disp_rs1_busy;
    logic [NUM_DISP-1:0]       disp_rs2_busy;
    logic [NUM_DISP*TAG_W-1:0] disp_rs1_tag;
    logic [NUM_DISP*TAG_W-1:0] disp_rs2_tag;
    logic [NUM_CDB-1:0]        cdb_wr;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*XLEN-1:0]   cdb_wdata;
    logic                      flush;
    logic [NUM_REGS-1:0]       busy_vec;

    modport master (
        output disp_rd_wr, disp_rd_addr, disp_rd_tag, disp_rs1_addr, disp_rs2_addr,
        output cdb_wr, cdb_tag, cdb_wdata, flush,
        input  disp_rs1_rdata, disp_rs2_rdata, disp_rs1_busy, disp_rs2_busy,
        input  disp_rs1_tag, disp_rs2_tag, busy_vec
    );

    modport slave (
        input  disp_rd_wr, disp_rd_addr, disp_rd_tag, disp_rs1_addr, disp_rs2_addr,
        input  cdb_wr, cdb_tag, cdb_wdata, flush,
        output disp_rs1_rdata, disp_rs2_rdata, disp_rs1_busy, disp_rs2_busy,
        output disp_rs1_tag, disp_rs2_tag, busy_vec
    );
endinterface

// File: rtl/rfu_mp.sv
// Multi-port register value/status file for the Tomasulo core.
// Holds value, busy flag and producer tag per architectural register, serves
// NUM_DISP dispatch lanes per cycle with intra-bundle rename forwarding and
// snoops NUM_CDB result buses with same-cycle bypass. Flush clears all
// producers while keeping values.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : rfu_mp_if slave (dispatch lanes, source reads, CDB, flush, busy_vec)
module rfu_mp #(
    parameter int TAG_W    = 4,
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_DISP = 2,
    parameter int NUM_CDB  = 2
) (
    input logic   clk,
    input logic   rst_n,
    rfu_mp_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0]     mem_q  [NUM_REGS];
    logic [XLEN-1:0]     mem_d  [NUM_REGS];
    logic [TAG_W-1:0]    tag_q  [NUM_REGS];
    logic [TAG_W-1:0]    tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Per-register CDB match against the stored producer tag.
    logic [NUM_REGS-1:0] cdb_hit;
    logic [XLEN-1:0]     cdb_data [NUM_REGS];
    logic                cdb_dup;

    logic [NUM_DISP*XLEN-1:0]  rd_data [2];
    logic [NUM_DISP-1:0]       rd_busy [2];
    logic [NUM_DISP*TAG_W-1:0] rd_tag  [2];

    // Descending scan so the lowest-index matching CDB wins.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cdb_hit[r]  = 1'b0;
            cdb_data[r] = '0;
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (busy_q[r] && bus.cdb_wr[c] &&
                    bus.cdb_tag[c*TAG_W +: TAG_W] != '0 &&
                    bus.cdb_tag[c*TAG_W +: TAG_W] == tag_q[r]) begin
                    cdb_hit[r]  = 1'b1;
                    cdb_data[r] = bus.cdb_wdata[c*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        cdb_dup = 1'b0;
        for (int a = 0; a < NUM_CDB; a++) begin
            for (int b = a + 1; b < NUM_CDB; b++) begin
                if (bus.cdb_wr[a] && bus.cdb_wr[b] &&
                    bus.cdb_tag[a*TAG_W +: TAG_W] != '0 &&
                    bus.cdb_tag[a*TAG_W +: TAG_W] == bus.cdb_tag[b*TAG_W +: TAG_W])
                    cdb_dup = 1'b1;
            end
        end
    end

    // Next state: flush beats allocation, allocation beats CDB clearing of
    // busy/tag, but a CDB hit on the old tag still lands its value in mem.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            mem_d[r]  = mem_q[r];
            busy_d[r] = busy_q[r];
            tag_d[r]  = tag_q[r];
            if (r == 0) begin
                mem_d[r]  = '0;
                busy_d[r] = 1'b0;
                tag_d[r]  = '0;
            end else if (bus.flush) begin
                busy_d[r] = 1'b0;
                tag_d[r]  = '0;
            end else begin
                if (cdb_hit[r]) begin
                    mem_d[r]  = cdb_data[r];
                    busy_d[r] = 1'b0;
                    tag_d[r]  = '0;
                end
                // Ascending lane scan: the youngest allocating lane wins.
                for (int k = 0; k < NUM_DISP; k++) begin
                    if (bus.disp_rd_wr[k] && bus.disp_rd_addr[k*AW +: AW] == AW'(r)) begin
                        busy_d[r] = 1'b1;
                        tag_d[r]  = bus.disp_rd_tag[k*TAG_W +: TAG_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
                tag_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= mem_d[r];
                tag_q[r] <= tag_d[r];
            end
            busy_q <= busy_d;
        end
    end

    // Source reads. Only older lanes (j < k) rename; a lane's own rd never
    // shadows its own sources. Flush has no effect on same-cycle reads.
    always_comb begin
        logic [AW-1:0]    src;
        logic             renamed;
        logic [TAG_W-1:0] rtag;
        src     = '0;
        renamed = 1'b0;
        rtag    = '0;
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = '0;
            rd_tag[p]  = '0;
        end
        for (int k = 0; k < NUM_DISP; k++) begin
            for (int p = 0; p < 2; p++) begin
                src = (p == 0) ? bus.disp_rs1_addr[k*AW +: AW] : bus.disp_rs2_addr[k*AW +: AW];
                renamed = 1'b0;
                rtag    = '0;
                for (int j = 0; j < k; j++) begin
                    if (bus.disp_rd_wr[j] && bus.disp_rd_addr[j*AW +: AW] == src) begin
                        renamed = 1'b1;
                        rtag    = bus.disp_rd_tag[j*TAG_W +: TAG_W];
                    end
                end
                if (src != '0) begin
                    if (renamed) begin
                        rd_busy[p][k]              = 1'b1;
                        rd_tag[p][k*TAG_W +: TAG_W] = rtag;
                    end else if (cdb_hit[src]) begin
                        rd_data[p][k*XLEN +: XLEN] = cdb_data[src];
                    end else begin
                        rd_data[p][k*XLEN +: XLEN]  = mem_q[src];
                        rd_busy[p][k]               = busy_q[src];
                        rd_tag[p][k*TAG_W +: TAG_W] = tag_q[src];
                    end
                end
            end
        end
    end

    assign bus.disp_rs1_rdata = rd_data[0];
    assign bus.disp_rs2_rdata = rd_data[1];
    assign bus.disp_rs1_busy  = rd_busy[0];
    assign bus.disp_rs2_busy  = rd_busy[1];
    assign bus.disp_rs1_tag   = rd_tag[0];
    assign bus.disp_rs2_tag   = rd_tag[1];
    assign bus.busy_vec       = {busy_q[NUM_REGS-1:1], 1'b0};

    // Two CDBs never carry the same live tag in one cycle.
    a_cdb_unique: assert property (@(posedge clk) disable iff (!rst_n) !cdb_dup);

endmodule

// File: doc/rfu_mp.md
Name: rfu_mp

Overview:
- Parametrised multi-port register status and value file for the Tomasulo core, generalising the single-dispatch, single-CDB rfu.
- Holds the architectural value, busy flag and producer tag for each register.
- Serves NUM_DISP dispatch lanes per cycle, with intra-bundle rename forwarding.
- Snoops NUM_CDB result buses with same-cycle bypass and supports a global flush. Sits between decode/dispatch and the reservation stations.

Parameters:
- TAG_W, 4, producer tag width; tag 0 is reserved as "no producer".
- XLEN, 32, data width.
- NUM_REGS, 32, architectural register count; AW = $clog2(NUM_REGS).
- NUM_DISP, 2, dispatch lanes per cycle; lane 0 is oldest.
- NUM_CDB, 2, CDB broadcast ports.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- disp_rd_wr  in  NUM_DISP  lane k allocates rd.
- disp_rd_addr  in  NUM_DISP*AW  destination register per lane.
- disp_rd_tag  in  NUM_DISP*TAG_W  new producer tag per lane.
- disp_rs1_addr / disp_rs2_addr  in  NUM_DISP*AW  source addresses per lane.
- disp_rs1_rdata / disp_rs2_rdata  out  NUM_DISP*XLEN  source value.
- disp_rs1_busy / disp_rs2_busy  out  NUM_DISP  source still pending.
- disp_rs1_tag / disp_rs2_tag  out  NUM_DISP*TAG_W  pending producer tag (0 if not busy).
- cdb_wr  in  NUM_CDB  broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  broadcast tag.
- cdb_wdata  in  NUM_CDB*XLEN  broadcast data.
- flush  in  1  squash all in-flight producers.
- busy_vec  out  NUM_REGS  busy flag per register (debug/stall logic).

Behaviour:
- Reset (rst_n low, asynchronous): every mem, busy and tag clears to 0 immediately. All read outputs and busy_vec are then 0.
- Register 0: never written, never busy. Reads of x0 return data 0, busy 0, tag 0, regardless of lanes or CDB.
- CDB effective hit: cdb_wr[c] && cdb_tag[c] != 0. Tag-0 broadcasts are ignored.
- Per-register next state, highest priority first:
  1. flush: busy←0, tag←0, mem unchanged. Dispatch and CDB are ignored this cycle.
  2. Any lane allocates this rd: busy←1, tag←tag of the highest-index allocating lane. mem is still written if a CDB matches the old tag.
  3. CDB hit on the stored tag (busy==1): mem←wdata, busy←0, tag←0.
- Multiple CDBs carrying the same nonzero tag in one cycle is illegal (assertion). The RTL picks the lowest index.
- Read path, combinational, per lane k and source s, in priority order:
  - (a) s==0 → 0/0/0.
  - (b) Intra-bundle rename: a lane j<k with disp_rd_wr[j] and rd==s → busy 1, tag of the highest such j, data don't-care (drive 0).
  - (c) Stored busy and a CDB hit matches the stored tag → data=cdb_wdata, busy 0, tag 0.
  - (d) Otherwise stored mem/busy/tag.
- A lane's own rd allocation never affects its own sources (old mapping is read).
- flush does not alter same-cycle read outputs; its effect is visible the next cycle.
- busy_vec is registered state (pre-update), bit 0 tied to 0.
- Latency: state updates land on the next clk edge; reads are zero-cycle.

Test Plan:
- Reset mid-run: busy x5 (tag 3), assert rst_n low between edges → busy_vec==0 and rs1(x5) reads 0/0/0 without waiting for clk.
- Dispatch x5 tag 3, then cdb0 tag 3 data 0xDEADBEEF while lane0 reads x5 → same-cycle rdata 0xDEADBEEF, busy 0; next cycle stored busy 0, value retained.
- Lane0 writes x7 tag 2, lane1 writes x7 tag 4 and reads rs1=x7 → lane1 sees busy 1 tag 2. Next cycle x7 tag 4; cdb tag 2 later → no change.
- Two CDBs at once: cdb0 tag 1 → x1 0x11, cdb1 tag 6 → x9 0x99 → both written, both busy cleared.
- Redispatch race: x5 busy tag 3; same cycle lane0 allocates x5 tag 5 and cdb tag 3 data 0x55 → mem=0x55, busy 1, tag 5.
- Flush with x2,x3 busy plus concurrent dispatch x4 tag 1 and cdb hit → next cycle busy_vec==0, x2/x3 mem unchanged, x4 not busy.
